// File: rtl/chien_forney_ctx_seq_pkg.sv
// ---------------------------------------------------------------------------
// ecc_seq_pkg
// Shared types and constants for the Chien/Forney context sequencer.
//   W      : GF symbol width
//   T      : correction capability (sigma has T+1 terms, v has T)
//   ID_W   : codeword tag width
//   CNT_W  : width of degree / correction counts, $clog2(T+1)
//   state_t  : sequencer FSM states
//   ctx_t    : one buffered RiBM result
//   status_t : one per-codeword status record
// ---------------------------------------------------------------------------
package ecc_seq_pkg;

   localparam int W    = 10;
   localparam int T    = 11;
   localparam int ID_W = 4;

   function automatic int cnt_width(input int t);
      return $clog2(t + 1);
   endfunction

   localparam int CNT_W = cnt_width(T);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      START  = 3'd2,
      RUN    = 3'd3,
      DRAIN  = 3'd4,
      REPORT = 3'd5
   } state_t;

   typedef struct packed {
      logic [T:0][W-1:0]   sigma;
      logic [T-1:0][W-1:0] v;
      logic [CNT_W-1:0]    deg;
      logic [ID_W-1:0]     id;
   } ctx_t;

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [CNT_W-1:0] ncorr;
      logic             exceed;
      logic             mismatch;
      logic             timeout;
   } status_t;

endpackage

// File: rtl/chien_forney_ctx_seq_fifo.sv
// ---------------------------------------------------------------------------
// ecc_ctx_fifo
// Small context FIFO holding RiBM results until the engine is free.
//   clk, rst_n : clock, asynchronous active-low reset (clears storage too)
//   flush      : synchronous clear of pointers/count; beats push and pop
//   push       : write wr_data (ignored when full)
//   wr_data    : payload to write
//   pop        : advance the read pointer (ignored when empty)
//   head       : entry at the read pointer
//   full/empty : occupancy flags
//   count      : number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// ---------------------------------------------------------------------------
module ecc_ctx_fifo
   import ecc_seq_pkg::*;
#(
   parameter int  DEPTH     = 4,
   parameter type payload_t = ctx_t
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  payload_t                 wr_data,
   input  logic                     pop,
   output payload_t                 head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   payload_t        mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            push_ok;
   logic            pop_ok;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/chien_forney_ctx_seq.sv
// ---------------------------------------------------------------------------
// chien_forney_ctx_seq
// Buffers RiBM results and feeds them one at a time to the Chien + Forney
// engine, then returns one in-order status record per codeword.
// Symbol width, T and tag width come from ecc_seq_pkg (they size ctx_t).
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   flush_i                  : synchronous abort of all contexts
//   in_vld_i / in_rdy_o      : context handshake (sigma, v, deg, id)
//   eng_sigma_o / eng_v_o    : head context towards the engine
//   eng_cw_start_o, eng_sigma_vld_o, eng_start_o : one-cycle engine pulses
//   eng_chien_done_i, eng_ecc_vld_i, eng_exceed_i,
//   eng_recorrect_done_i, eng_corr_i             : engine events
//   st_vld_o / st_rdy_i      : status handshake
//   st_id_o, st_ncorr_o, st_exceed_o, st_mismatch_o, st_timeout_o : status
//   dbg_state_o              : current FSM state
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high at the rising edge; valid-side payload is held stable until then.
// ---------------------------------------------------------------------------
module chien_forney_ctx_seq
   import ecc_seq_pkg::*;
#(
   parameter int CTX_DEPTH   = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  in_vld_i,
   output logic                  in_rdy_o,
   input  logic [T:0][W-1:0]     in_sigma_i,
   input  logic [T-1:0][W-1:0]   in_v_i,
   input  logic [CNT_W-1:0]      in_deg_i,
   input  logic [ID_W-1:0]       in_id_i,
   output logic [T:0][W-1:0]     eng_sigma_o,
   output logic [T-1:0][W-1:0]   eng_v_o,
   output logic                  eng_cw_start_o,
   output logic                  eng_sigma_vld_o,
   output logic                  eng_start_o,
   input  logic                  eng_chien_done_i,
   input  logic                  eng_ecc_vld_i,
   input  logic                  eng_exceed_i,
   input  logic                  eng_recorrect_done_i,
   input  logic                  eng_corr_i,
   output logic                  st_vld_o,
   input  logic                  st_rdy_i,
   output logic [ID_W-1:0]       st_id_o,
   output logic [CNT_W-1:0]      st_ncorr_o,
   output logic                  st_exceed_o,
   output logic                  st_mismatch_o,
   output logic                  st_timeout_o,
   output state_t                dbg_state_o
);

   localparam int AW   = $clog2(CTX_DEPTH);
   localparam int WD_W = $clog2(TIMEOUT_CYC);
   localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] NCORR_MAX = CNT_W'(T);
   localparam logic [AW:0]      ONE_CNT = (AW + 1)'(1);

   // ------------------------------------------------------------------
   // Context FIFO
   // ------------------------------------------------------------------
   ctx_t          in_ctx;
   ctx_t          head;
   logic          full;
   logic          empty;
   logic [AW:0]   count;
   logic          push;
   logic          pop;

   assign in_ctx.sigma = in_sigma_i;
   assign in_ctx.v     = in_v_i;
   assign in_ctx.deg   = in_deg_i;
   assign in_ctx.id    = in_id_i;

   assign in_rdy_o = ~full;
   // A push is refused while full even if the head pops this cycle.
   assign push     = in_vld_i & ~full;

   ecc_ctx_fifo #(
      .DEPTH     (CTX_DEPTH),
      .payload_t (ctx_t)
   ) u_fifo (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .flush   (flush_i),
      .push    (push),
      .wr_data (in_ctx),
      .pop     (pop),
      .head    (head),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   // ------------------------------------------------------------------
   // FSM and per-codeword counters
   // ------------------------------------------------------------------
   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  ncorr;
   logic [CNT_W-1:0]  ncorr_nxt;
   logic              exceed;
   logic              exceed_nxt;
   logic              rec_seen;
   logic              rec_seen_nxt;
   logic [WD_W-1:0]   wdog;
   logic [WD_W-1:0]   wdog_nxt;
   logic              wdog_hit;
   logic              counting;
   logic              enter_report;
   status_t           status;

   assign st_vld_o = (state == REPORT);
   assign pop      = st_vld_o & st_rdy_i;

   always_comb begin
      state_nxt    = state;
      ncorr_nxt    = ncorr;
      exceed_nxt   = exceed;
      rec_seen_nxt = rec_seen;
      wdog_nxt     = wdog;
      wdog_hit     = 1'b0;
      counting     = 1'b0;
      enter_report = 1'b0;

      case (state)
         IDLE: begin
            // A push this cycle is already visible at the head next cycle.
            if (!empty || push) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            state_nxt = START;
         end
         START: begin
            ncorr_nxt    = '0;
            exceed_nxt   = 1'b0;
            rec_seen_nxt = 1'b0;
            wdog_nxt     = '0;
            state_nxt    = RUN;
         end
         RUN: begin
            counting = 1'b1;
            if (eng_ecc_vld_i && eng_exceed_i) begin
               exceed_nxt = 1'b1;
            end
            if (eng_recorrect_done_i) begin
               rec_seen_nxt = 1'b1;
            end
            if (eng_chien_done_i) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            counting = 1'b1;
            if (eng_recorrect_done_i || rec_seen) begin
               state_nxt    = REPORT;
               enter_report = 1'b1;
            end else if (wdog == WD_LAST) begin
               wdog_hit     = 1'b1;
               state_nxt    = REPORT;
               enter_report = 1'b1;
            end else begin
               wdog_nxt = wdog + 1'b1;
            end
         end
         REPORT: begin
            if (st_rdy_i) begin
               // Post-pop occupancy, including a push landing this cycle.
               state_nxt = ((count != ONE_CNT) || push) ? LOAD : IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Corrections accepted on a transition cycle still count.
      if (counting && eng_corr_i && (ncorr != NCORR_MAX)) begin
         ncorr_nxt = ncorr + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         ncorr    <= '0;
         exceed   <= 1'b0;
         rec_seen <= 1'b0;
         wdog     <= '0;
         status   <= '0;
      end else if (flush_i) begin
         state    <= IDLE;
         ncorr    <= '0;
         exceed   <= 1'b0;
         rec_seen <= 1'b0;
         wdog     <= '0;
         status   <= '0;
      end else begin
         state    <= state_nxt;
         ncorr    <= ncorr_nxt;
         exceed   <= exceed_nxt;
         rec_seen <= rec_seen_nxt;
         wdog     <= wdog_nxt;
         if (enter_report) begin
            status.id       <= head.id;
            status.ncorr    <= ncorr_nxt;
            status.exceed   <= exceed_nxt;
            status.mismatch <= (ncorr_nxt != head.deg);
            status.timeout  <= wdog_hit;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs (Moore pulses and registered status)
   // ------------------------------------------------------------------
   assign eng_sigma_o     = head.sigma;
   assign eng_v_o         = head.v;
   assign eng_cw_start_o  = (state == LOAD);
   assign eng_sigma_vld_o = (state == LOAD);
   assign eng_start_o     = (state == START);

   assign st_id_o       = status.id;
   assign st_ncorr_o    = status.ncorr;
   assign st_exceed_o   = status.exceed;
   assign st_mismatch_o = status.mismatch;
   assign st_timeout_o  = status.timeout;

   assign dbg_state_o = state;

endmodule

// File: tb/tb_chien_forney_ctx_seq.sv
// ---------------------------------------------------------------------------
// tb_chien_forney_ctx_seq
// Self-checking bench: table-driven codeword vectors, hand-written corner
// sequences (startup timing, full FIFO, watchdog, status hold, flush, reset)
// and a randomized stream checked against a reference status model.
// ---------------------------------------------------------------------------
module tb_chien_forney_ctx_seq;
   import ecc_seq_pkg::*;

   localparam int CTX_DEPTH = 4;
   localparam int TO_CYC    = 64;
   localparam int ST_W      = ID_W + CNT_W + 3;
   localparam int N_RAND    = 24;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic                  flush_i;
   logic                  in_vld_i;
   logic                  in_rdy_o;
   logic [T:0][W-1:0]     in_sigma_i;
   logic [T-1:0][W-1:0]   in_v_i;
   logic [CNT_W-1:0]      in_deg_i;
   logic [ID_W-1:0]       in_id_i;
   logic [T:0][W-1:0]     eng_sigma_o;
   logic [T-1:0][W-1:0]   eng_v_o;
   logic                  eng_cw_start_o;
   logic                  eng_sigma_vld_o;
   logic                  eng_start_o;
   logic                  eng_chien_done_i;
   logic                  eng_ecc_vld_i;
   logic                  eng_exceed_i;
   logic                  eng_recorrect_done_i;
   logic                  eng_corr_i;
   logic                  st_vld_o;
   logic                  st_rdy_i;
   logic [ID_W-1:0]       st_id_o;
   logic [CNT_W-1:0]      st_ncorr_o;
   logic                  st_exceed_o;
   logic                  st_mismatch_o;
   logic                  st_timeout_o;
   state_t                dbg_state_o;

   chien_forney_ctx_seq #(
      .CTX_DEPTH   (CTX_DEPTH),
      .TIMEOUT_CYC (TO_CYC)
   ) dut (
      .clk_i                (clk),
      .rst_ni               (rst_n),
      .flush_i              (flush_i),
      .in_vld_i             (in_vld_i),
      .in_rdy_o             (in_rdy_o),
      .in_sigma_i           (in_sigma_i),
      .in_v_i               (in_v_i),
      .in_deg_i             (in_deg_i),
      .in_id_i              (in_id_i),
      .eng_sigma_o          (eng_sigma_o),
      .eng_v_o              (eng_v_o),
      .eng_cw_start_o       (eng_cw_start_o),
      .eng_sigma_vld_o      (eng_sigma_vld_o),
      .eng_start_o          (eng_start_o),
      .eng_chien_done_i     (eng_chien_done_i),
      .eng_ecc_vld_i        (eng_ecc_vld_i),
      .eng_exceed_i         (eng_exceed_i),
      .eng_recorrect_done_i (eng_recorrect_done_i),
      .eng_corr_i           (eng_corr_i),
      .st_vld_o             (st_vld_o),
      .st_rdy_i             (st_rdy_i),
      .st_id_o              (st_id_o),
      .st_ncorr_o           (st_ncorr_o),
      .st_exceed_o          (st_exceed_o),
      .st_mismatch_o        (st_mismatch_o),
      .st_timeout_o         (st_timeout_o),
      .dbg_state_o          (dbg_state_o)
   );

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;
   int starts_seen = 0;
   int starts_used = 0;
   int cw_pulses   = 0;
   int n_pops      = 0;
   logic prev_start;
   logic prev_cw;
   logic [T:0][W-1:0]   last_sigma;
   logic [T-1:0][W-1:0] last_v;
   logic [ST_W-1:0] exp_q[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse monitors: count control pulses and flag any pulse wider than a cycle.
   always @(posedge clk) begin
      if (eng_start_o) starts_seen++;
      if (eng_cw_start_o) cw_pulses++;
      if (rst_n && ((eng_start_o && prev_start) || (eng_cw_start_o && prev_cw))) begin
         n_checks++;
         n_fail++;
         $display("FAIL pulse_width: engine control pulse held longer than one cycle");
      end
      prev_start <= eng_start_o;
      prev_cw    <= eng_cw_start_o;
   end

   // ---------------- reference model ----------------
   function automatic logic [ST_W-1:0] model(input int id, input int deg, input int nc,
                                             input bit exc, input int rec);
      int n;
      logic [ST_W-1:0] r;
      n = (nc > T) ? T : nc;
      r = {ID_W'(id), CNT_W'(n), exc, (n != deg), (rec < 0)};
      return r;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic push_ctx(input int id, input int deg);
      int n;
      for (int j = 0; j <= T; j++) in_sigma_i[j] = W'($urandom_range(0, (1 << W) - 1));
      for (int j = 0; j < T; j++)  in_v_i[j]     = W'($urandom_range(0, (1 << W) - 1));
      last_sigma = in_sigma_i;
      last_v     = in_v_i;
      in_id_i  = ID_W'(id);
      in_deg_i = CNT_W'(deg);
      in_vld_i = 1'b1;
      n = 0;
      while (!in_rdy_o && n < 3000) begin
         tick();
         n++;
      end
      n_checks++;
      if (!in_rdy_o) begin
         n_fail++;
         $display("FAIL push_wait: in_rdy_o still %0b after %0d cycles, required 1", in_rdy_o, n);
      end
      tick();
      in_vld_i = 1'b0;
   endtask

   task automatic wait_start(output bit ok);
      int n;
      n = 0;
      while (starts_seen <= starts_used && n < 3000) begin
         tick();
         n++;
      end
      ok = (starts_seen > starts_used);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL start_wait: no eng_start_o within %0d cycles (seen %0d, required > %0d)",
                  n, starts_seen, starts_used);
      end else begin
         starts_used++;
      end
   endtask

   // Engine model: cycle k=0 is the first RUN cycle. Corrections on k<nc,
   // done + ecc_vld on k=run_len, recorrect on k=run_len+rec (never if rec<0).
   task automatic engine(input int run_len, input int nc, input bit exc, input int rec);
      bit ok;
      int last;
      wait_start(ok);
      if (ok) begin
         last = run_len + ((rec > 0) ? rec : 0);
         for (int k = 0; k <= last; k++) begin
            eng_corr_i           = (k < nc);
            eng_chien_done_i     = (k == run_len);
            eng_ecc_vld_i        = (k == run_len);
            eng_exceed_i         = (k == run_len) && exc;
            eng_recorrect_done_i = (rec >= 0) && (k == run_len + rec);
            tick();
         end
      end
      eng_corr_i           = 1'b0;
      eng_chien_done_i     = 1'b0;
      eng_ecc_vld_i        = 1'b0;
      eng_exceed_i         = 1'b0;
      eng_recorrect_done_i = 1'b0;
   endtask

   task automatic get_status(input int hold, output logic [ST_W-1:0] st, output int lat);
      lat = 0;
      while (!st_vld_o && lat < 3000) begin
         tick();
         lat++;
      end
      n_checks++;
      if (!st_vld_o) begin
         n_fail++;
         $display("FAIL status_wait: st_vld_o still 0 after %0d cycles, required 1", lat);
      end
      st = {st_id_o, st_ncorr_o, st_exceed_o, st_mismatch_o, st_timeout_o};
      repeat (hold) tick();
      st_rdy_i = 1'b1;
      tick();
      st_rdy_i = 1'b0;
      n_pops++;
   endtask

   task automatic check_status(input logic [ST_W-1:0] st);
      logic [ST_W-1:0] e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL sb_empty: status %0h arrived with no expected record", st);
      end else begin
         e = exp_q.pop_front();
         chk("status_record", st, e);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int id;
      int deg;
      int nc;
      int run_len;
      bit exc;
      int rec;
      logic [ST_W-1:0] exp;
   } vec_t;

   vec_t vt[5];

   function automatic vec_t mk(input int id, input int deg, input int nc, input int run_len,
                               input bit exc, input int rec, input logic [ST_W-1:0] exp);
      vec_t v;
      v.id = id; v.deg = deg; v.nc = nc; v.run_len = run_len;
      v.exc = exc; v.rec = rec; v.exp = exp;
      return v;
   endfunction

   // ---------------- random stream storage ----------------
   int r_deg[N_RAND];
   int r_nc[N_RAND];
   int r_run[N_RAND];
   bit r_exc[N_RAND];
   int r_rec[N_RAND];

   // ---------------- main sequence ----------------
   initial begin
      logic [ST_W-1:0] st;
      int lat;
      int cw_before;
      bit ok;

      vt[0] = mk(3, 2, 2, 10, 1'b0, 3,  {4'd3, 4'd2,  1'b0, 1'b0, 1'b0});
      vt[1] = mk(5, 12, 11, 12, 1'b1, 2, {4'd5, 4'd11, 1'b1, 1'b1, 1'b0});
      vt[2] = mk(6, 11, 13, 14, 1'b0, 0, {4'd6, 4'd11, 1'b0, 1'b0, 1'b0});
      vt[3] = mk(7, 4, 3, 5, 1'b0, 1,   {4'd7, 4'd3,  1'b0, 1'b1, 1'b0});
      vt[4] = mk(9, 0, 0, 3, 1'b0, -1,  {4'd9, 4'd0,  1'b0, 1'b0, 1'b1});

      rst_n = 1'b0; flush_i = 1'b0; in_vld_i = 1'b0; st_rdy_i = 1'b0;
      in_sigma_i = '0; in_v_i = '0; in_deg_i = '0; in_id_i = '0;
      eng_corr_i = 1'b0; eng_chien_done_i = 1'b0; eng_ecc_vld_i = 1'b0;
      eng_exceed_i = 1'b0; eng_recorrect_done_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset state
      chk("rst_in_rdy", in_rdy_o, 1);
      chk("rst_st_vld", st_vld_o, 0);
      chk("rst_eng_pulses", {eng_cw_start_o, eng_sigma_vld_o, eng_start_o}, 0);
      chk("rst_eng_sigma", eng_sigma_o, 0);
      chk("rst_eng_v", eng_v_o, 0);
      chk("rst_status", {st_id_o, st_ncorr_o, st_exceed_o, st_mismatch_o, st_timeout_o}, 0);
      chk("rst_state", dbg_state_o, IDLE);
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();

      // Single codeword: startup timing and status latency
      push_ctx(3, 2);
      chk("load_pulse", {eng_cw_start_o, eng_sigma_vld_o, eng_start_o}, 3'b110);
      chk("load_sigma", eng_sigma_o, last_sigma);
      chk("load_v", eng_v_o, last_v);
      tick();
      chk("start_pulse", {eng_cw_start_o, eng_sigma_vld_o, eng_start_o}, 3'b001);
      exp_q.push_back({4'd3, 4'd2, 1'b0, 1'b0, 1'b0});
      engine(10, 2, 1'b0, 3);
      get_status(0, st, lat);
      chk("status_latency", lat, 0);
      check_status(st);
      tick();

      // Table-driven vectors
      for (int i = 0; i < 5; i++) begin
         push_ctx(vt[i].id, vt[i].deg);
         engine(vt[i].run_len, vt[i].nc, vt[i].exc, vt[i].rec);
         get_status(0, st, lat);
         chk($sformatf("vec%0d_status", i), st, vt[i].exp);
         tick();
      end

      // Watchdog: status exactly TIMEOUT_CYC cycles after DRAIN entry
      push_ctx(9, 1);
      engine(4, 1, 1'b0, -1);
      chk("drain_entry_state", dbg_state_o, DRAIN);
      get_status(0, st, lat);
      chk("timeout_latency", lat, TO_CYC);
      chk("timeout_status", st, {4'd9, 4'd1, 1'b0, 1'b0, 1'b1});
      tick();

      // Full FIFO with stalled engine; fifth push only after first pop
      for (int i = 0; i < 4; i++) begin
         push_ctx(i, 1);
         exp_q.push_back(model(i, 1, 1, 1'b0, 1));
      end
      chk("full_in_rdy", in_rdy_o, 0);
      n_pops = 0;
      fork
         begin
            push_ctx(4, 1);
            chk("push5_after_pop", (n_pops >= 1), 1);
            exp_q.push_back(model(4, 1, 1, 1'b0, 1));
         end
         begin
            repeat (5) tick();
            chk("still_full", in_rdy_o, 0);
            for (int i = 0; i < 5; i++) begin
               engine(3, 1, 1'b0, 1);
               get_status(0, st, lat);
               check_status(st);
            end
         end
      join
      tick();

      // Status hold for 20 cycles, then LOAD right after the handshake
      push_ctx(1, 0);
      push_ctx(2, 0);
      engine(2, 0, 1'b0, 1);
      lat = 0;
      while (!st_vld_o && lat < 100) begin
         tick();
         lat++;
      end
      for (int i = 0; i < 20; i++) begin
         chk($sformatf("hold_c%0d", i),
             {st_vld_o, st_id_o, st_ncorr_o, st_exceed_o, st_mismatch_o, st_timeout_o},
             {1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0});
         tick();
      end
      st_rdy_i = 1'b1;
      tick();
      st_rdy_i = 1'b0;
      chk("load_after_hs", eng_cw_start_o, 1);
      exp_q.push_back({4'd2, 4'd0, 1'b0, 1'b0, 1'b0});
      engine(2, 0, 1'b0, 1);
      get_status(0, st, lat);
      check_status(st);
      tick();

      // Flush in DRAIN with 3 contexts queued; concurrent push discarded
      push_ctx(10, 0);
      push_ctx(11, 0);
      push_ctx(12, 0);
      engine(2, 0, 1'b0, -1);
      chk("pre_flush_state", dbg_state_o, DRAIN);
      flush_i  = 1'b1;
      in_vld_i = 1'b1;
      in_id_i  = 4'd14;
      tick();
      flush_i  = 1'b0;
      in_vld_i = 1'b0;
      chk("flush_state", dbg_state_o, IDLE);
      chk("flush_in_rdy", in_rdy_o, 1);
      chk("flush_st_vld", st_vld_o, 0);
      cw_before = cw_pulses;
      repeat (5) tick();
      chk("flush_fifo_empty", cw_pulses - cw_before, 0);
      chk("flush_idle_hold", dbg_state_o, IDLE);
      push_ctx(15, 1);
      exp_q.push_back({4'd15, 4'd1, 1'b0, 1'b0, 1'b0});
      engine(3, 1, 1'b0, 1);
      get_status(0, st, lat);
      check_status(st);
      tick();

      // Reset mid-RUN
      push_ctx(4, 0);
      push_ctx(5, 0);
      wait_start(ok);
      repeat (3) tick();
      chk("pre_reset_state", dbg_state_o, RUN);
      #2 rst_n = 1'b0;
      #1;
      chk("areset_state", dbg_state_o, IDLE);
      chk("areset_in_rdy", in_rdy_o, 1);
      chk("areset_st_vld", st_vld_o, 0);
      chk("areset_sigma", eng_sigma_o, 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      tick();
      chk("post_reset_idle", {dbg_state_o, eng_cw_start_o}, {IDLE, 1'b0});
      starts_used = starts_seen;

      // Randomized stream against the reference model
      for (int i = 0; i < N_RAND; i++) begin
         r_nc[i]  = $urandom_range(0, 13);
         r_run[i] = r_nc[i] + $urandom_range(0, 3);
         r_exc[i] = 1'($urandom_range(0, 1));
         r_deg[i] = ($urandom_range(0, 1) == 1) ? ((r_nc[i] > T) ? T : r_nc[i])
                                                : $urandom_range(0, 12);
         r_rec[i] = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 4);
      end
      fork
         begin
            for (int i = 0; i < N_RAND; i++) begin
               repeat ($urandom_range(0, 6)) tick();
               push_ctx(i % 16, r_deg[i]);
               exp_q.push_back(model(i % 16, r_deg[i], r_nc[i], r_exc[i], r_rec[i]));
            end
         end
         begin
            for (int i = 0; i < N_RAND; i++) begin
               engine(r_run[i], r_nc[i], r_exc[i], r_rec[i]);
               get_status($urandom_range(0, 3), st, lat);
               check_status(st);
            end
         end
      join
      repeat (3) tick();

      chk("sb_drained", exp_q.size(), 0);
      chk("pulse_balance", cw_pulses, starts_seen);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time limit
   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "time limit");
   end

endmodule

// File: doc/chien_forney_ctx_seq.md
# chien_forney_ctx_seq

Multi-codeword context sequencer in front of the Chien + Forney engine. Buffers up to CTX_DEPTH RiBM results (σ, v, expected degree, codeword ID), then feeds them one at a time to the engine with the load/start pulse sequence. It collects the engine's completion, exceed and correction events, and returns one in-order status record per codeword. This keeps RiBM running while the engine is busy.

## Interface
- W, 10, GF symbol width
- T, 11, correction capability; σ has T+1 terms, v has T
- CTX_DEPTH, 4, context FIFO entries (power of two, ≥2)
- ID_W, 4, codeword tag width
- TIMEOUT_CYC, 64, drain watchdog limit in cycles (≥2)
- CNT_W, localparam $clog2(T+1)
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous abort; clears all contexts
- in_vld_i / in_rdy_o  in/out  1  RiBM context handshake
- in_sigma_i  in  W×[0:T]  σ, low order first
- in_v_i  in  W×[0:T-1]  v, low order first
- in_deg_i  in  CNT_W  deg σ reported by RiBM
- in_id_i  in  ID_W  codeword tag
- eng_sigma_o / eng_v_o  out  as inputs  head context, to engine
- eng_cw_start_o, eng_sigma_vld_o, eng_start_o  out  1  engine control pulses
- eng_chien_done_i, eng_ecc_vld_i, eng_exceed_i, eng_recorrect_done_i  in  1  engine events
- eng_corr_i  in  1  one Forney output accepted (vld & rdy)
- st_vld_o / st_rdy_i  out/in  1  status handshake
- st_id_o  out  ID_W; st_ncorr_o  out  CNT_W; st_exceed_o, st_mismatch_o, st_timeout_o  out  1

## Operation
- **Context FIFO:** CTX_DEPTH entries; pointers wrap modulo CTX_DEPTH.
  - in_rdy_o = !full (combinational).
  - Push on in_vld_i & in_rdy_o. Write is registered.
  - A push is refused when full, even if a pop occurs in the same cycle.
  - The head entry is popped only on the status handshake.
- **FSM states:**
  - IDLE: go to LOAD if the FIFO is non-empty.
  - LOAD: eng_cw_start_o = eng_sigma_vld_o = 1 for one cycle, with eng_sigma_o/eng_v_o = head. Go to START.
  - START: eng_start_o = 1 for one cycle. Clear ncorr, the flags and the watchdog. Go to RUN.
  - RUN: count eng_corr_i. Latch exceed on eng_ecc_vld_i & eng_exceed_i. Latch recorrect_seen on eng_recorrect_done_i. Go to DRAIN on eng_chien_done_i.
  - DRAIN: keep counting. Exit when eng_recorrect_done_i or recorrect_seen is set. Otherwise the watchdog increments; on reaching TIMEOUT_CYC−1, set timeout and exit. Next state is REPORT.
  - REPORT: st_vld_o = 1 until st_rdy_i. On the handshake, pop the head, then go to LOAD if the post-pop count is >0, else IDLE.
- **ncorr:** saturating at T (CNT_W wide).
- **mismatch:** = (ncorr ≠ head deg); evaluated when entering REPORT.
- **Simultaneous events:** eng_ecc_vld_i and eng_chien_done_i in the same cycle are both honoured.
  - eng_corr_i in the cycle of the RUN→DRAIN or DRAIN→REPORT transition still counts.
- **flush_i:** wins over every other event.
  - Empties the FIFO and forces IDLE.
  - Drops st_vld_o and zeroes the counters.
  - An in_vld_i in the same cycle is discarded.
- **Reset mid-operation:** same effect as flush, applied asynchronously.

## Timing
- **Reset values:** all registered outputs 0. FIFO storage is 0, so eng_sigma_o/eng_v_o = 0. in_rdy_o = 1.
- **Startup:** push at cycle c into an empty FIFO in IDLE gives LOAD at c+1, START at c+2, RUN at c+3.
- **Status latency:** st_vld_o rises the cycle after the DRAIN exit condition.
- **Status hold:** all st_* outputs are registered and stay stable while st_vld_o & !st_rdy_i.
- **Back-to-back:** with the FIFO non-empty, the REPORT handshake at cycle r gives LOAD at r+1. The minimum codeword period is engine time + 4 cycles.
- **Engine outputs:** eng_* control outputs are Moore outputs; each is high for exactly one cycle per codeword.

## Structure
- **Package ecc_seq_pkg:**
  - state enum {IDLE, LOAD, START, RUN, DRAIN, REPORT}
  - ctx_t struct (sigma, v, deg, id)
  - status_t struct (id, ncorr, exceed, mismatch, timeout)
  - CNT_W helper function
- **Sub-module ecc_ctx_fifo:** parametrised by CTX_DEPTH and payload type ctx_t; exposes head, full, empty and count.
- **Top:** holds the FSM, counters, watchdog and status register.

## Test plan
- One context (id=3, deg=2); engine gives done at RUN+10, 2 eng_corr_i pulses, recorrect_done 3 cycles later → status {id=3, ncorr=2, exceed=0, mismatch=0, timeout=0}; LOAD at c+1, START at c+2.
- Push 5 contexts with CTX_DEPTH=4 and the engine stalled → in_rdy_o=0 after the 4th; 5th accepted only after the first pop; statuses return in ID order 0..4.
- eng_ecc_vld_i & eng_exceed_i coincident with done, deg=12 clipped to the 11-error path, 11 corrections → exceed=1, ncorr=11, mismatch=1.
- recorrect_done never asserted, TIMEOUT_CYC=64 → st_vld_o exactly 64 cycles after DRAIN entry, timeout=1.
- st_rdy_i held low 20 cycles → st_* stable; the next LOAD occurs the cycle after the handshake.
- flush_i asserted in DRAIN with 3 contexts queued → next cycle IDLE, FIFO empty, st_vld_o=0; reset mid-RUN behaves identically.
